// File: rtl/instruction_fetch_queue_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
//   NOP             : instruction presented while the queue is empty
//   PC_INC          : byte stride between sequential instructions
//   is_word_aligned : true when a byte address is on a 32-bit boundary
package instruction_fetch_queue_pkg;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam int unsigned PC_INC = 4;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding prefetched {instruction, next_pc} entries.
//   i_clk, i_reset : clock, async active-high reset (clears pointers and count)
//   i_flush        : synchronous clear; overrides push and pop
//   i_push, i_data : write one entry
//   i_pop          : advance head; ignored when empty
//   o_head         : entry at the read pointer
//   o_empty        : no entries held
//   o_count        : occupied entries, 0..DEPTH
module fetch_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_eff;

    assign pop_eff = i_pop && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (i_push && !pop_eff) begin
            count_d = count_q + 1'b1;
        end else if (!i_push && pop_eff) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (i_flush) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (i_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_eff) begin
                rd_q <= rd_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) begin
            mem_q[wr_q] <= i_data;
        end
    end

    assign o_head  = mem_q[rd_q];
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

    // The issuer's credit check must make overflow impossible.
    assert property (@(posedge i_clk) disable iff (i_reset)
        !(i_push && !i_flush && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/rom_memory32.sv
// Synchronous program ROM, one word per read-enabled clock.
//   i_clk       : clock, rising edge
//   i_r_en      : read enable; o_data updates at the edge when high
//   i_address   : word index
//   o_data      : registered read data
//   i_w_en      : load strobe, honoured only when no INIT_FILE image is used
//   i_w_address : load word index
//   i_w_data    : load data
module rom_memory32 #(
    parameter int unsigned NB_DATA   = 32,
    parameter int unsigned N_WORDS   = 128,
    parameter int unsigned NB_ADDR   = $clog2(N_WORDS),
    parameter string       INIT_FILE = ""
) (
    input  logic               i_clk,
    input  logic               i_r_en,
    input  logic [NB_ADDR-1:0] i_address,
    output logic [NB_DATA-1:0] o_data,
    input  logic               i_w_en,
    input  logic [NB_ADDR-1:0] i_w_address,
    input  logic [NB_DATA-1:0] i_w_data
);

    // A file-backed image is read-only; otherwise the load port fills it.
    localparam bit WRITABLE = (INIT_FILE == "");

    logic [NB_DATA-1:0] mem [N_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_w_en && WRITABLE) begin
            mem[i_w_address] <= i_w_data;
        end
        if (i_r_en) begin
            o_data <= mem[i_address];
        end
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Prefetching instruction fetch stage between the program ROM and IF/ID.
//   i_clk, i_reset  : clock, async active-high reset
//   i_stall         : consumer not accepting; head held
//   i_branch        : one-cycle redirect request to i_branch_addr
//   o_instruction   : head instruction, NOP when !o_valid
//   o_next_pc_1     : head PC + 4, 0 when !o_valid
//   o_valid         : head entry valid
//   o_misaligned    : one-cycle pulse after a branch with target[1:0] != 0
//   o_queue_count   : occupied queue entries
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int unsigned NB_DATA        = 32,
    parameter int unsigned NB_ADDRESS     = 32,
    parameter int unsigned N_MEM_ADDRESS  = 128,
    parameter int unsigned NB_MEM_ADDRESS = $clog2(N_MEM_ADDRESS) + 2,
    parameter int unsigned QUEUE_DEPTH    = 4,
    parameter int unsigned RESET_PC       = 0,
    parameter string       INIT_FILE      = ""
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_stall,
    input  logic                         i_branch,
    input  logic [NB_ADDRESS-1:0]        i_branch_addr,
    output logic [NB_DATA-1:0]           o_instruction,
    output logic [NB_ADDRESS-1:0]        o_next_pc_1,
    output logic                         o_valid,
    output logic                         o_misaligned,
    output logic [$clog2(QUEUE_DEPTH):0] o_queue_count
);

    localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned ENTRY_W = NB_DATA + NB_ADDRESS;
    localparam int unsigned ROM_AW  = NB_MEM_ADDRESS - 2;

    logic [NB_ADDRESS-1:0] fetch_pc_q;
    logic [NB_ADDRESS-1:0] inflight_npc_q;
    logic                  inflight_q;
    logic                  misaligned_q;
    logic                  branch_taken;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    logic [NB_DATA-1:0]    rom_data;
    logic [ENTRY_W-1:0]    head;

    assign branch_taken = i_branch && is_word_aligned(i_branch_addr[1:0]);

    // Reserve a slot for the read in flight so a response always has room.
    assign issue = !branch_taken &&
                   ((count + CNT_W'(inflight_q)) < CNT_W'(QUEUE_DEPTH));

    // A redirect kills the response arriving this cycle.
    assign push = inflight_q && !branch_taken;
    assign pop  = o_valid && !i_stall;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fetch_pc_q     <= NB_ADDRESS'(RESET_PC);
            inflight_q     <= 1'b0;
            inflight_npc_q <= '0;
            misaligned_q   <= 1'b0;
        end else begin
            if (branch_taken) begin
                fetch_pc_q <= i_branch_addr;
            end else if (issue) begin
                fetch_pc_q <= fetch_pc_q + NB_ADDRESS'(PC_INC);
            end
            inflight_q     <= issue;
            inflight_npc_q <= fetch_pc_q + NB_ADDRESS'(PC_INC);
            misaligned_q   <= i_branch && !is_word_aligned(i_branch_addr[1:0]);
        end
    end

    rom_memory32 #(
        .NB_DATA   (NB_DATA),
        .N_WORDS   (N_MEM_ADDRESS),
        .NB_ADDR   (ROM_AW),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .i_clk       (i_clk),
        .i_r_en      (issue),
        .i_address   (fetch_pc_q[NB_MEM_ADDRESS-1:2]),
        .o_data      (rom_data),
        .i_w_en      (1'b0),
        .i_w_address ({ROM_AW{1'b0}}),
        .i_w_data    ({NB_DATA{1'b0}})
    );

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (branch_taken),
        .i_push  (push),
        .i_data  ({rom_data, inflight_npc_q}),
        .i_pop   (pop),
        .o_head  (head),
        .o_empty (empty),
        .o_count (count)
    );

    assign o_valid       = !empty;
    assign o_instruction = o_valid ? head[ENTRY_W-1 -: NB_DATA] : NB_DATA'(NOP);
    assign o_next_pc_1   = o_valid ? head[NB_ADDRESS-1:0] : '0;
    assign o_misaligned  = misaligned_q;
    assign o_queue_count = count;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] baddr;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
    logic        mis;
    logic [2:0]  cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instruction_fetch_queue dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_stall       (stall),
        .i_branch      (branch),
        .i_branch_addr (baddr),
        .o_instruction (instr),
        .o_next_pc_1   (npc),
        .o_valid       (valid),
        .o_misaligned  (mis),
        .o_queue_count (cnt)
    );

    typedef struct {
        logic        stall;
        logic        branch;
        logic [31:0] baddr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] npc;
        logic [2:0]  cnt;
        logic        mis;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] a,
                                input logic v, input logic [31:0] i, input logic [31:0] n,
                                input logic [2:0] c, input logic m);
        vec_t r;
        r.stall = s; r.branch = b; r.baddr = a;
        r.valid = v; r.instr = i; r.npc = n; r.cnt = c; r.mis = m;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [31:0] i,
                              input logic [31:0] n, input logic [2:0] c, input logic m);
        check({tag, " valid"}, {31'b0, valid}, {31'b0, v});
        check({tag, " instr"}, instr, i);
        check({tag, " next_pc"}, npc, n);
        check({tag, " count"}, {29'b0, cnt}, {29'b0, c});
        check({tag, " misaligned"}, {31'b0, mis}, {31'b0, m});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Cycle index counts from the first cycle after reset release.
        vecs[0]  = mk(0, 0, 32'h0,   0, 32'h0,         32'h0,   3'd0, 0);
        vecs[1]  = mk(0, 0, 32'h0,   0, 32'h0,         32'h0,   3'd0, 0);
        vecs[2]  = mk(1, 0, 32'h0,   1, 32'h1000_0000, 32'h4,   3'd1, 0);
        vecs[3]  = mk(1, 0, 32'h0,   1, 32'h1000_0000, 32'h4,   3'd2, 0);
        vecs[4]  = mk(1, 0, 32'h0,   1, 32'h1000_0000, 32'h4,   3'd3, 0);
        for (int k = 5; k <= 11; k++)
            vecs[k] = mk(1, 0, 32'h0, 1, 32'h1000_0000, 32'h4, 3'd4, 0);
        vecs[12] = mk(0, 0, 32'h0,   1, 32'h1000_0000, 32'h4,   3'd4, 0);
        vecs[13] = mk(0, 1, 32'h40,  1, 32'h1000_0001, 32'h8,   3'd3, 0);
        vecs[14] = mk(0, 0, 32'h0,   0, 32'h0,         32'h0,   3'd0, 0);
        vecs[15] = mk(0, 0, 32'h0,   0, 32'h0,         32'h0,   3'd0, 0);
        vecs[16] = mk(0, 0, 32'h0,   1, 32'h1000_0010, 32'h44,  3'd1, 0);
        vecs[17] = mk(0, 0, 32'h0,   1, 32'h1000_0011, 32'h48,  3'd1, 0);
        vecs[18] = mk(0, 1, 32'h42,  1, 32'h1000_0012, 32'h4c,  3'd1, 0);
        vecs[19] = mk(0, 0, 32'h0,   1, 32'h1000_0013, 32'h50,  3'd1, 1);
        vecs[20] = mk(1, 1, 32'h80,  1, 32'h1000_0014, 32'h54,  3'd1, 0);
        vecs[21] = mk(0, 0, 32'h0,   0, 32'h0,         32'h0,   3'd0, 0);
        vecs[22] = mk(0, 0, 32'h0,   0, 32'h0,         32'h0,   3'd0, 0);
        vecs[23] = mk(0, 0, 32'h0,   1, 32'h1000_0020, 32'h84,  3'd1, 0);
        vecs[24] = mk(0, 1, 32'h1fc, 1, 32'h1000_0021, 32'h88,  3'd1, 0);
        vecs[25] = mk(0, 0, 32'h0,   0, 32'h0,         32'h0,   3'd0, 0);
        vecs[26] = mk(0, 0, 32'h0,   0, 32'h0,         32'h0,   3'd0, 0);
        vecs[27] = mk(0, 0, 32'h0,   1, 32'h1000_007f, 32'h200, 3'd1, 0);
        vecs[28] = mk(0, 0, 32'h0,   1, 32'h1000_0000, 32'h204, 3'd1, 0);

        for (int k = 0; k < 128; k++) begin
            dut.u_rom.mem[k] = 32'h1000_0000 + k;
        end

        rst = 1'b1; stall = 1'b0; branch = 1'b0; baddr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outs("reset", 0, 32'h0, 32'h0, 3'd0, 0);
        rst = 1'b0;

        for (int k = 0; k < NVEC; k++) begin
            if (k > 0) next_cycle();
            stall  = vecs[k].stall;
            branch = vecs[k].branch;
            baddr  = vecs[k].baddr;
            check_outs($sformatf("c%0d", k), vecs[k].valid, vecs[k].instr,
                       vecs[k].npc, vecs[k].cnt, vecs[k].mis);
        end
        stall = 1'b0; branch = 1'b0; baddr = '0;

        // Reset asserted between edges clears outputs without a clock.
        next_cycle();
        check_outs("pre_rst", 1, 32'h1000_0001, 32'h208, 3'd1, 0);
        #2 rst = 1'b1;
        #1 check_outs("async_rst", 0, 32'h0, 32'h0, 3'd0, 0);
        next_cycle();
        rst = 1'b0;
        check_outs("rst_c0", 0, 32'h0, 32'h0, 3'd0, 0);
        next_cycle();
        check_outs("rst_c1", 0, 32'h0, 32'h0, 3'd0, 0);
        next_cycle();
        check_outs("rst_c2", 1, 32'h1000_0000, 32'h4, 3'd1, 0);
        next_cycle();
        check_outs("rst_c3", 1, 32'h1000_0001, 32'h8, 3'd1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
Parametrised successor to the single-register fetch stage. It decouples PC generation from the decode stage through a QUEUE_DEPTH-entry prefetch queue fed by the synchronous program ROM (rom_memory32). It handles branch redirects by flushing the queue and killing any read in flight. Misaligned branch targets are rejected and flagged instead of being silently dropped. It sits between the program ROM and the IF/ID boundary.

Parameters:
NB_DATA, 32, instruction width
NB_ADDRESS, 32, PC width
N_MEM_ADDRESS, 128, ROM words
NB_MEM_ADDRESS, $clog2(N_MEM_ADDRESS)+2, byte-address bits used for ROM indexing
QUEUE_DEPTH, 4, prefetch entries; power of two, >=2
RESET_PC, 0, PC loaded on reset; word aligned
INIT_FILE, "", ROM init file

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_stall  in  1  consumer not accepting; head is held
i_branch  in  1  redirect request, single-cycle qualifier
i_branch_addr  in  NB_ADDRESS  redirect target
o_instruction  out  NB_DATA  head instruction; 0 (NOP) when !o_valid
o_next_pc_1  out  NB_ADDRESS  PC of head + 4; 0 when !o_valid
o_valid  out  1  head entry valid
o_misaligned  out  1  one-cycle pulse: branch rejected, target[1:0]!=0
o_queue_count  out  $clog2(QUEUE_DEPTH)+1  occupied entries

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc=RESET_PC; queue empty; in-flight flag=0.
  - All outputs 0.
- Issue rule, cycle N: issue = !branch_taken & (count + inflight < QUEUE_DEPTH).
  - When issue is high: rom i_r_en=1, address fetch_pc[NB_MEM_ADDRESS-1:2], inflight<=1, fetch_pc<=fetch_pc+4.
  - PC wraps modulo 2^NB_ADDRESS; ROM index wraps modulo N_MEM_ADDRESS.
- Response: ROM data appears in N+1. If inflight and not killed, push {data, pc+4} at the end of N+1. The entry is visible at the head in N+2.
  - Latency from issue to o_valid is 2 cycles.
  - Throughput is 1 instruction per cycle when not stalled.
- Pop: o_valid & !i_stall advances the head at the edge.
  - Push and pop in the same cycle leave count unchanged.
  - Stall never changes o_instruction or o_next_pc_1.
- Full: the credit check (count+inflight) guarantees no push into a full queue. Overflow is impossible by construction; assert in simulation.
- Empty: o_valid=0, o_instruction=0, o_next_pc_1=0. A pop request while empty is ignored.
- Aligned branch (i_branch & addr[1:0]==0), branch_taken=1:
  - At the edge: queue cleared, rd/wr pointers reset, in-flight response killed (not pushed), fetch_pc<=i_branch_addr.
  - The target issues in N+1 and is visible in N+3.
  - Branch has priority over stall and over push/pop in the same cycle.
- Misaligned branch (i_branch & addr[1:0]!=0):
  - Redirect ignored; fetch and queue continue unchanged.
  - o_misaligned=1 in the following cycle only (registered).
- Pointers: rd/wr of $clog2(QUEUE_DEPTH) bits wrap naturally. count is held separately (0..QUEUE_DEPTH).
- Reset mid-operation: asynchronously clears everything, including the in-flight flag. The ROM response arriving after release is discarded because inflight=0.

Decomposition:
- Package: nop code 32'h0000_0000, PC increment constant 4, helper function for aligned check.
- Sub-module: fetch_queue (sync FIFO with flush, push/pop, count; entries NB_DATA+NB_ADDRESS wide).
- rom_memory32 is reused unchanged.
- The top contains the PC/issue/kill logic.

Test Plan:
- Reset release, ROM word i = 32'h1000_0000+i, no stall -> cycle 2: o_valid=1, o_instruction=32'h1000_0000, o_next_pc_1=4; then one word per cycle (32'h1000_0001, next_pc 8, ...).
- Stall held from cycle 2 for 10 cycles -> o_queue_count rises to 4 and holds; ROM i_r_en=0 once full. After release, the sequence continues with no gap and no duplicate.
- Aligned branch to 32'h40 while the queue holds 3 entries -> next cycle o_valid=0, count=0; two cycles later head=32'h1000_0010, o_next_pc_1=32'h44. No stale word ever appears.
- Branch to 32'h42 -> o_misaligned pulses 1 cycle; the instruction stream continues sequentially and unchanged.
- i_branch and i_stall in the same cycle -> branch wins: flush, redirect, o_valid=0 next cycle.
- i_reset asserted mid-stream between clock edges -> outputs 0 immediately (async). After release, fetch restarts at RESET_PC; the first valid word is 32'h1000_0000 after 2 cycles.
